// File: rtl/imem_loader.sv
// Instruction-memory boot loader: receives a byte-stream image (16-bit word count,
// little-endian words, XOR checksum), fills the memory, then releases the processor.
module imem_loader #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic [31:0] PC,
  output logic [31:0] Inst,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_error
);

  typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, RUN, ERR} state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [1:0]            bidx_q, bidx_d;
  logic [ADDR_WIDTH-1:0] widx_q, widx_d;
  logic [23:0]           word_q, word_d;
  logic [7:0]            csum_q, csum_d;
  logic                  cpu_reset_q, done_q, err_q;

  logic                  xfer;
  logic                  we;
  logic [31:0]           wdata;
  logic [15:0]           hdr_cnt;
  logic                  last_word;

  logic [31:0]           mem [DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0] raddr;
  logic                  pc_in_range;
  logic                  unused_pc_bits;

  assign byte_ready = (state_q != RUN) && (state_q != ERR);
  assign xfer       = byte_valid && byte_ready;
  assign hdr_cnt    = {byte_in, cnt_q[7:0]};
  assign wdata      = {byte_in, word_q};
  assign last_word  = ({{(16-ADDR_WIDTH){1'b0}}, widx_q} == (cnt_q - 16'd1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    widx_d  = widx_q;
    word_d  = word_q;
    csum_d  = csum_q;
    we      = 1'b0;
    unique case (state_q)
      HDR0: if (xfer) begin
        cnt_d[7:0] = byte_in;
        state_d    = HDR1;
      end
      HDR1: if (xfer) begin
        cnt_d[15:8] = byte_in;
        if (hdr_cnt == 16'd0)              state_d = CSUM;
        else if ({1'b0, hdr_cnt} > DEPTH_L) state_d = ERR;
        else                               state_d = DATA;
      end
      DATA: if (xfer) begin
        // Bytes shift in from the top so the first byte lands in bits 7:0.
        csum_d = csum_q ^ byte_in;
        bidx_d = bidx_q + 2'd1;
        word_d = {byte_in, word_q[23:8]};
        if (bidx_q == 2'd3) begin
          we = 1'b1;
          if (last_word) state_d = CSUM;
          else           widx_d  = widx_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      CSUM: if (xfer) begin
        state_d = (byte_in == csum_q) ? RUN : ERR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= HDR0;
      cnt_q       <= '0;
      bidx_q      <= '0;
      widx_q      <= '0;
      word_q      <= '0;
      csum_q      <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bidx_q      <= bidx_d;
      widx_q      <= widx_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
      cpu_reset_q <= (state_d != RUN);
      done_q      <= (state_d == RUN);
      err_q       <= (state_d == ERR);
    end
  end

  // Memory is deliberately left out of reset so an aborted load keeps what it wrote.
  always_ff @(posedge clock) begin
    if (we) mem[widx_q] <= wdata;
  end

  assign raddr          = PC[ADDR_WIDTH+1:2];
  assign pc_in_range    = (PC[31:ADDR_WIDTH+2] == '0);
  assign unused_pc_bits = ^PC[1:0];
  assign Inst           = ((state_q == RUN) && pc_in_range) ? mem[raddr] : 32'h0000_0000;

  assign cpu_reset  = cpu_reset_q;
  assign load_done  = done_q;
  assign load_error = err_q;

endmodule
